// File: rtl/gpo_display_scanner.sv
// Scans a 32-bit value onto an 8-digit common-anode seven-segment display.
// Ports: CLK, RST_N (sync, active-low), DIN value, CFG control,
//        AN/SEG/DP active-low drives, FRAME pulse on snapshot load.
module gpo_display_scanner #(
   parameter int TICKS_PER_DIGIT = 50000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] DIN,
   input  logic [31:0] CFG,
   output logic [7:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic        FRAME
);

   localparam int PW = (TICKS_PER_DIGIT > 2) ?
                       $clog2(TICKS_PER_DIGIT) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_DIGIT - 1);

   logic [PW-1:0] p;
   logic [2:0]    idx;
   logic [31:0]   sd;
   logic [31:0]   sc;

   logic          p_wrap;
   logic          boundary;
   logic [3:0]    nib;
   logic [31:0]   upper;
   logic          blank;
   logic [7:0]    dp_mask;
   logic [6:0]    glyph;
   logic [7:0]    an_nx;
   logic [6:0]    seg_nx;
   logic          dp_nx;
   logic          unused_sc;

   assign unused_sc = ^{sc[31:16], sc[7:2]};

   always_comb begin
      p_wrap   = (p == P_LAST);
      boundary = p_wrap && (idx == 3'd7);
      nib      = sd[{idx, 2'b00} +: 4];
      // Digit is a leading zero when it and every higher nibble are zero.
      upper    = sd >> {idx, 2'b00};
      blank    = sc[1] && (idx != 3'd0) && (upper == 32'd0);
      dp_mask  = sc[15:8];
   end

   always_comb begin
      case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   end

   always_comb begin
      an_nx  = 8'hFF;
      seg_nx = 7'h7F;
      dp_nx  = 1'b1;
      if (sc[0] && !blank) begin
         an_nx  = ~(8'd1 << idx);
         seg_nx = glyph;
         dp_nx  = ~dp_mask[idx];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         p     <= '0;
         idx   <= 3'd0;
         sd    <= 32'd0;
         sc    <= 32'd0;
         AN    <= 8'hFF;
         SEG   <= 7'h7F;
         DP    <= 1'b1;
         FRAME <= 1'b0;
      end else begin
         p <= p_wrap ? '0 : p + PW'(1);
         if (p_wrap) begin
            idx <= idx + 3'd1;
         end
         // Snapshot only at the frame boundary so mid-frame writes never tear.
         if (boundary) begin
            sd <= DIN;
            sc <= CFG;
         end
         FRAME <= boundary;
         AN    <= an_nx;
         SEG   <= seg_nx;
         DP    <= dp_nx;
      end
   end

endmodule

// File: tb/tb_gpo_display_scanner.sv
// Bench for gpo_display_scanner with TICKS_PER_DIGIT = 4 (frame = 32).
// Cycle model plus directed literal checks of the display sequence.
module tb_gpo_display_scanner;

   localparam int T = 4;
   localparam int F = 8 * T;

   logic        clk;
   logic        rst_n;
   logic [31:0] din;
   logic [31:0] cfg;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   int errors = 0;
   int checks = 0;

   gpo_display_scanner #(.TICKS_PER_DIGIT(T)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .DIN   (din),
      .CFG   (cfg),
      .AN    (an),
      .SEG   (seg),
      .DP    (dp),
      .FRAME (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] segtab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Model: edges since reset release, snapshot copies, expected outputs.
   int          t;
   int          m_idx;
   bit          m_blank;
   bit          mv = 0;
   logic [31:0] md;
   logic [31:0] mc;
   logic [7:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dp;
   logic        m_fr;

   always @(posedge clk) begin
      if (!rst_n) begin
         t = 0; md = 0; mc = 0;
         m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_fr = 1'b0;
         mv = 1;
      end else if (mv) begin
         m_idx   = (t / T) % 8;
         m_blank = 0;
         if (mc[1] && m_idx != 0) begin
            m_blank = 1;
            for (int k = m_idx; k < 8; k++)
               if (((md >> (4 * k)) & 32'hF) != 0) m_blank = 0;
         end
         m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
         if (mc[0] && !m_blank) begin
            m_an[m_idx] = 1'b0;
            m_seg = segtab[(md >> (4 * m_idx)) & 32'hF];
            m_dp  = ~mc[8 + m_idx];
         end
         m_fr = ((t % F) == F - 1);
         if (m_fr) begin
            md = din;
            mc = cfg;
         end
         t++;
      end
   end

   always @(negedge clk) begin
      if (mv) begin
         checks++;
         if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_fr}) begin
            errors++;
            $display("FAIL model t=%0d: got an=%h seg=%h dp=%b fr=%b want an=%h seg=%h dp=%b fr=%b",
                     t, an, seg, dp, frame, m_an, m_seg, m_dp, m_fr);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns the number of negedges until FRAME is seen; -1 on timeout.
   task automatic wait_frame(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (frame === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         errors++;
         checks++;
         $display("FAIL frame_timeout: got none want pulse within 200");
      end
   endtask

   logic [7:0] an_tab  [8];
   logic [6:0] seg_tab [8];
   int n;

   initial begin
      rst_n = 1'b0;
      din   = 32'hFFFF_FFFF;
      cfg   = 32'hFFFF_FFFF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("rst_out", {an, seg, dp, frame}, {8'hFF, 7'h7F, 1'b1, 1'b0});
      end

      // Scan of 12345678
      din   = 32'h1234_5678;
      cfg   = 32'h0000_0001;
      rst_n = 1'b1;
      wait_frame(n);
      chk("first_frame_edge", n, F);
      an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      seg_tab = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
      for (int d = 0; d < 8; d++)
         for (int j = 0; j < T; j++) begin
            @(negedge clk);
            chk("scan", {an, seg, dp}, {an_tab[d], seg_tab[d], 1'b1});
         end

      // Leading-zero blanking of 00000A05
      din = 32'h0000_0A05;
      cfg = 32'h0000_0003;
      wait_frame(n);
      an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      seg_tab = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      for (int d = 0; d < 8; d++) begin
         step(1);
         chk("lzb_a05", {an, seg}, {an_tab[d], seg_tab[d]});
         step(T - 1);
      end

      // All-zero value blanked down to digit 0
      din = 32'h0;
      cfg = 32'h3;
      wait_frame(n);
      step(1);
      chk("lzb_zero_d0", {an, seg}, {8'hFE, 7'h40});
      step(T);
      chk("lzb_zero_d1", {an, seg}, {8'hFF, 7'h7F});

      // Decimal points on digits 0 and 2
      cfg = 32'h0000_0501;
      wait_frame(n);
      for (int d = 0; d < 8; d++) begin
         step(1);
         chk("dp_mask", {an, dp}, {~(8'd1 << d), (d == 0 || d == 2) ? 1'b0 : 1'b1});
         step(T - 1);
      end
      cfg = 32'h0000_0500;
      wait_frame(n);
      step(1);
      chk("disabled_d0", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
      step(2 * T);
      chk("disabled_d2", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});

      // Tearing: DIN change mid-frame waits for the next boundary
      din = 32'h1111_1111;
      cfg = 32'h0000_0001;
      wait_frame(n);
      step(3 * T + 1);
      din = 32'h2222_2222;
      for (int i = 0; i < 200; i++) begin
         if (frame === 1'b1) break;
         chk("tear_hold", seg, 7'h79);
         @(negedge clk);
      end
      chk("tear_frame_seen", frame, 1'b1);
      wait_frame(n);
      chk("frame_period", n, F);
      step(1);
      chk("frame_width", frame, 1'b0);
      chk("tear_new_d0", {an, seg}, {8'hFE, 7'h24});

      // Reset pulse while digit 5 is scanned
      step(5 * T - 1);
      rst_n = 1'b0;
      step(1);
      chk("midrst_out", {an, seg, dp, frame}, {8'hFF, 7'h7F, 1'b1, 1'b0});
      rst_n = 1'b1;
      step(T);
      chk("midrst_dark", {an, seg}, {8'hFF, 7'h7F});
      wait_frame(n);
      chk("midrst_frame", n, F - T);
      step(1);
      chk("midrst_resume", {an, seg}, {8'hFE, 7'h24});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpo_display_scanner.md
# gpo_display_scanner

Memory-mapped output consumer that sits directly downstream of the GPIO block's GPO1/GPO2 registers. It drives an 8-digit, common-anode, multiplexed seven-segment display from a 32-bit value as eight hex digits. Display control (enable, leading-zero blanking, decimal points) comes from a 32-bit config word. Both words are snapshotted once per scan frame so a CPU write mid-frame never tears the display.

## Interface
- TICKS_PER_DIGIT, 50000: CLK cycles each digit stays lit. Must be ≥ 2. Frame length F = 8 × TICKS_PER_DIGIT cycles.
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- DIN  in  32  display value (from GPIO GPO1); nibble i = digit i, digit 0 = least significant
- CFG  in  32  control (from GPIO GPO2): [0] EN, [1] LZB leading-zero blank, [15:8] DP mask (bit 8+i = decimal point of digit i); other bits ignored
- AN  out  8  digit anodes, active-low
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low
- FRAME  out  1  one-cycle pulse marking a snapshot load

## Operation
- State: prescaler P (0..TICKS_PER_DIGIT−1), digit index IDX (3 bits), snapshot registers SD (32) and SC (32), registered outputs AN/SEG/DP/FRAME.
- Reset (RST_N low at an edge):
  - P = 0, IDX = 0, SD = 0, SC = 0
  - AN = 8'hFF, SEG = 7'h7F, DP = 1, FRAME = 0
- Reset wins over every other event.
- Each edge: P increments. At P == TICKS_PER_DIGIT−1:
  - P wraps to 0
  - IDX increments, wrapping 7 → 0
- Frame boundary (edge where P == TICKS_PER_DIGIT−1 and IDX == 7):
  - SD ← DIN, SC ← CFG
  - FRAME ← 1 for exactly that following cycle; otherwise FRAME ← 0
- Output register, loaded every edge from the current IDX/SD/SC (values before that edge's updates):
  - SC[0] == 0: AN = FF, SEG = 7F, DP = 1. Scanning and snapshotting continue.
  - Digit IDX blanked (SC[1] == 1, IDX ≠ 0, and SD nibbles IDX..7 all zero): AN = FF, SEG = 7F, DP = 1
  - Otherwise: AN = ~(1 << IDX), SEG = hex(SD nibble IDX), DP = ~SC[8+IDX]
- Hex decode, nibble → SEG:
  - 0 → 40, 1 → 79, 2 → 24, 3 → 30
  - 4 → 19, 5 → 12, 6 → 02, 7 → 78
  - 8 → 00, 9 → 10, A → 08, b → 03
  - C → 46, d → 21, E → 06, F → 0E
- AN is never more than one digit low.

## Timing
- Snapshot latency:
  - First snapshot load happens on the F-th rising edge with RST_N high after reset.
  - Until then SC = 0, so the display is dark.
  - Loads then repeat every F cycles; FRAME pulses with period exactly F.
- Output latency: outputs lag IDX/snapshot by one cycle.
  - After a frame-boundary edge, the next edge presents digit 0 of the new snapshot.
  - Each digit is then held for TICKS_PER_DIGIT cycles.
- Tearing: DIN/CFG changes between boundaries have no effect until the next boundary. A change on the boundary edge itself is captured.
- Reset mid-frame: the outputs show reset values on the cycle after the reset edge. The next snapshot load is F edges after release.

## Test plan
Bench runs with TICKS_PER_DIGIT = 4, so F = 32.
- Reset: hold RST_N low 40 cycles with DIN = FFFFFFFF, CFG = FFFFFFFF -> AN = FF, SEG = 7F, DP = 1, FRAME = 0 throughout. After release, first FRAME arrives on the 32nd edge.
- Scan: DIN = 12345678, CFG = 00000001 -> after FRAME, outputs step through the digits in order, each held 4 cycles:
  - AN FE / SEG 00, AN FD / SEG 78, AN FB / SEG 02, AN F7 / SEG 12
  - AN EF / SEG 19, AN DF / SEG 30, AN BF / SEG 24, AN 7F / SEG 79
  - DP = 1 throughout
- Blanking, DIN = 00000A05, CFG = 00000003 -> digit 0 SEG 12, digit 1 SEG 40, digit 2 SEG 08; digits 3..7 AN = FF.
- Blanking, DIN = 0, CFG = 3 -> only digit 0 lit, SEG 40.
- Decimal points: CFG = 00000501, DIN = 0 -> DP = 0 only while AN = FE or AN = FB. CFG = 00000500 -> fully dark.
- Tearing: change DIN from 11111111 to 22222222 while IDX = 3 -> SEG stays 79 until the next FRAME, then 24 from digit 0 on. FRAME is exactly one cycle wide and 32 cycles apart.
- Reset mid-frame: pulse RST_N low for one cycle while IDX = 5 -> reset output values on the next cycle, display dark, next FRAME 32 edges after release.
